// File: rtl/sram_avalon_ctrl.sv
// Avalon-MM slave bridging to an asynchronous SRAM (IS61LV25616 class) with programmable
// read/write wait states, read-to-write bus turnaround and byte-lane writes; all pins are flop outputs.
module sram_avalon_ctrl #(
   parameter int unsigned AW         = 18,
   parameter int unsigned DW         = 16,
   parameter int unsigned READ_WAIT  = 1,
   parameter int unsigned WRITE_WAIT = 1,
   parameter int unsigned TURNAROUND = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [AW-1:0]        avs_address,
   input  logic                 avs_read,
   input  logic                 avs_write,
   input  logic [DW-1:0]        avs_writedata,
   input  logic [DW/8-1:0]      avs_byteenable,
   output logic                 avs_waitrequest,
   output logic [DW-1:0]        avs_readdata,
   output logic                 avs_readdatavalid,
   output logic [AW-1:0]        sram_addr,
   inout  wire  [DW-1:0]        sram_dq,
   output logic                 sram_ce_n,
   output logic                 sram_oe_n,
   output logic                 sram_we_n,
   output logic [DW/8-1:0]      sram_be_n
);

   localparam int unsigned BW = DW / 8;
   localparam int unsigned CW = 4;
   localparam logic [CW-1:0] READ_LD  = CW'(READ_WAIT);
   localparam logic [CW-1:0] WRITE_LD = CW'(WRITE_WAIT);
   localparam logic [CW-1:0] TURN_LD  = (TURNAROUND > 0) ? CW'(TURNAROUND - 1) : '0;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_READ  = 3'd1,
      S_TURN  = 3'd2,
      S_WRITE = 3'd3,
      S_HOLD  = 3'd4
   } state_t;

   state_t            r_state;
   logic [CW-1:0]     r_cnt;
   logic [AW-1:0]     r_addr;
   logic [DW-1:0]     r_dq_out;
   logic              r_dq_oe;
   logic              r_ce_n;
   logic              r_oe_n;
   logic              r_we_n;
   logic [BW-1:0]     r_be_n;
   logic [DW-1:0]     r_rdata;
   logic              r_rdv;
   logic [DW-1:0]     w_dq_in;

   // Data pins are driven only while the write data output-enable flop is set.
   assign sram_dq = r_dq_oe ? r_dq_out : {DW{1'bz}};
   assign w_dq_in = sram_dq;

   assign avs_waitrequest   = reset | (r_state != S_IDLE);
   assign avs_readdata      = r_rdata;
   assign avs_readdatavalid = r_rdv;
   assign sram_addr         = r_addr;
   assign sram_ce_n         = r_ce_n;
   assign sram_oe_n         = r_oe_n;
   assign sram_we_n         = r_we_n;
   assign sram_be_n         = r_be_n;

   // Single registered FSM: every SRAM strobe is set on the edge that enters its phase.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_addr   <= '0;
         r_dq_out <= '0;
         r_dq_oe  <= 1'b0;
         r_ce_n   <= 1'b1;
         r_oe_n   <= 1'b1;
         r_we_n   <= 1'b1;
         r_be_n   <= {BW{1'b1}};
         r_rdata  <= '0;
         r_rdv    <= 1'b0;
      end else begin
         r_rdv <= 1'b0;
         case (r_state)
            S_IDLE: begin
               // Write has priority when both requests arrive together.
               if (avs_write) begin
                  r_state  <= S_WRITE;
                  r_cnt    <= WRITE_LD;
                  r_addr   <= avs_address;
                  r_dq_out <= avs_writedata;
                  r_dq_oe  <= 1'b1;
                  r_ce_n   <= 1'b0;
                  r_oe_n   <= 1'b1;
                  r_we_n   <= 1'b0;
                  r_be_n   <= ~avs_byteenable;
               end else if (avs_read) begin
                  r_state  <= S_READ;
                  r_cnt    <= READ_LD;
                  r_addr   <= avs_address;
                  r_dq_oe  <= 1'b0;
                  r_ce_n   <= 1'b0;
                  r_oe_n   <= 1'b0;
                  r_we_n   <= 1'b1;
                  r_be_n   <= '0;
               end
            end
            S_READ: begin
               if (r_cnt == '0) begin
                  r_rdata <= w_dq_in;
                  r_rdv   <= 1'b1;
                  r_ce_n  <= 1'b1;
                  r_oe_n  <= 1'b1;
                  r_be_n  <= {BW{1'b1}};
                  if (TURNAROUND > 0) begin
                     r_state <= S_TURN;
                     r_cnt   <= TURN_LD;
                  end else begin
                     r_state <= S_IDLE;
                  end
               end else begin
                  r_cnt <= r_cnt - CW'(1);
               end
            end
            S_TURN: begin
               if (r_cnt == '0) begin
                  r_state <= S_IDLE;
               end else begin
                  r_cnt <= r_cnt - CW'(1);
               end
            end
            S_WRITE: begin
               // WE rises first; address and data stay on the pins for one hold cycle.
               if (r_cnt == '0) begin
                  r_state <= S_HOLD;
                  r_we_n  <= 1'b1;
               end else begin
                  r_cnt <= r_cnt - CW'(1);
               end
            end
            S_HOLD: begin
               r_state <= S_IDLE;
               r_ce_n  <= 1'b1;
               r_be_n  <= {BW{1'b1}};
               r_dq_oe <= 1'b0;
            end
            default: begin
               r_state <= S_IDLE;
               r_ce_n  <= 1'b1;
               r_oe_n  <= 1'b1;
               r_we_n  <= 1'b1;
               r_be_n  <= {BW{1'b1}};
               r_dq_oe <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sram_avalon_ctrl.sv
// Directed bench for sram_avalon_ctrl with a behavioural async SRAM on the pins;
// table of Avalon transactions plus hand sequences for reset and turnaround corners.
module tb_sram_avalon_ctrl;

   localparam int unsigned AW = 18;
   localparam int unsigned DW = 16;
   localparam int unsigned BW = 2;

   logic           clk;
   logic           reset;
   logic [AW-1:0]  avs_address;
   logic           avs_read;
   logic           avs_write;
   logic [DW-1:0]  avs_writedata;
   logic [BW-1:0]  avs_byteenable;
   logic           avs_waitrequest;
   logic [DW-1:0]  avs_readdata;
   logic           avs_readdatavalid;
   logic [AW-1:0]  sram_addr;
   wire  [DW-1:0]  sram_dq;
   logic           sram_ce_n;
   logic           sram_oe_n;
   logic           sram_we_n;
   logic [BW-1:0]  sram_be_n;

   int n_chk;
   int n_err;

   sram_avalon_ctrl #(
      .AW(AW), .DW(DW), .READ_WAIT(1), .WRITE_WAIT(1), .TURNAROUND(1)
   ) dut (
      .clk(clk), .reset(reset),
      .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
      .avs_writedata(avs_writedata), .avs_byteenable(avs_byteenable),
      .avs_waitrequest(avs_waitrequest), .avs_readdata(avs_readdata),
      .avs_readdatavalid(avs_readdatavalid),
      .sram_addr(sram_addr), .sram_dq(sram_dq), .sram_ce_n(sram_ce_n),
      .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n), .sram_be_n(sram_be_n)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   // Behavioural SRAM: drives DQ while CE/OE low and WE high, writes enabled lanes on the clock.
   logic [DW-1:0] mem [0:(1<<AW)-1];
   logic          tb_drv;
   assign tb_drv  = !sram_ce_n && !sram_oe_n && sram_we_n;
   assign sram_dq = tb_drv ? mem[sram_addr] : {DW{1'bz}};

   always @(posedge clk) begin
      if (!sram_ce_n && !sram_we_n) begin
         if (!sram_be_n[0]) mem[sram_addr][7:0]  <= sram_dq[7:0];
         if (!sram_be_n[1]) mem[sram_addr][15:8] <= sram_dq[15:8];
      end
   end

   // Bus monitor: OE/WE overlap and gap between OE release and the next DQ drive.
   int cyc, last_oe, min_gap, overlap;
   logic prev_oe;
   initial begin
      cyc = 0; last_oe = -1000; min_gap = 99; overlap = 0; prev_oe = 1'b0;
   end
   always @(negedge clk) begin
      cyc = cyc + 1;
      if (!sram_oe_n) last_oe = cyc;
      if (!sram_oe_n && (!sram_we_n || dut.r_dq_oe)) overlap = overlap + 1;
      if (dut.r_dq_oe && !prev_oe && (cyc - last_oe - 1) < min_gap) min_gap = cyc - last_oe - 1;
      prev_oe = dut.r_dq_oe;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk = n_chk + 1;
      if (act !== exp) begin
         n_err = n_err + 1;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   typedef struct {
      string         name;
      logic          rd;
      logic          wr;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic [BW-1:0] be;
      int            exp_rdv;
      logic [DW-1:0] exp_rdata;
      int            exp_we;
      int            exp_oe;
      logic [BW-1:0] exp_ben;
      int            exp_occ;
   } vec_t;

   vec_t vecs [13];

   task automatic do_op(input vec_t v);
      int occ, we_c, oe_c, rdv_c, rdv_k, hold_c, guard;
      logic [DW-1:0] rdat, dqs;
      logic [BW-1:0] bes;
      guard = 0;
      while (avs_waitrequest && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      chk({v.name, "_idle"}, 32'(avs_waitrequest), 32'd0);
      avs_read = v.rd; avs_write = v.wr; avs_address = v.addr;
      avs_writedata = v.wdata; avs_byteenable = v.be;
      @(posedge clk);
      #1;
      avs_read = 1'b0; avs_write = 1'b0;
      occ = 0; we_c = 0; oe_c = 0; rdv_c = 0; rdv_k = 0; hold_c = 0;
      rdat = '0; dqs = '0; bes = '1;
      for (int k = 1; k <= 20 && occ == 0; k++) begin
         @(negedge clk);
         if (!sram_we_n) begin we_c++; bes = sram_be_n; dqs = sram_dq; end
         if (!sram_oe_n) oe_c++;
         if (!sram_ce_n && sram_we_n && dut.r_dq_oe) hold_c++;
         if (avs_readdatavalid) begin rdv_c++; rdv_k = k; rdat = avs_readdata; end
         if (!avs_waitrequest) occ = k;
      end
      chk({v.name, "_occ"}, 32'(occ), 32'(v.exp_occ));
      chk({v.name, "_we_cycles"}, 32'(we_c), 32'(v.exp_we));
      chk({v.name, "_oe_cycles"}, 32'(oe_c), 32'(v.exp_oe));
      chk({v.name, "_rdv_count"}, 32'(rdv_c), 32'(v.exp_rdv));
      chk({v.name, "_hold_cycles"}, 32'(hold_c), (v.exp_we > 0) ? 32'd1 : 32'd0);
      if (v.exp_rdv > 0) begin
         chk({v.name, "_rdv_cycle"}, 32'(rdv_k), 32'd3);
         chk({v.name, "_rdata"}, 32'(rdat), 32'(v.exp_rdata));
      end
      if (v.exp_we > 0) begin
         chk({v.name, "_be_n"}, 32'(bes), 32'(v.exp_ben));
         chk({v.name, "_dq"}, 32'(dqs), 32'(v.wdata));
      end
   endtask

   initial begin
      n_chk = 0; n_err = 0;
      //          name          rd    wr    addr        wdata     be     rdv data      we oe ben    occ
      vecs[0]  = '{"wr_a5c3",   1'b0, 1'b1, 18'h00010, 16'hA5C3, 2'b11, 0, 16'h0000, 2, 0, 2'b00, 4};
      vecs[1]  = '{"rd_a5c3",   1'b1, 1'b0, 18'h00010, 16'h0000, 2'b00, 1, 16'hA5C3, 0, 2, 2'b11, 4};
      vecs[2]  = '{"wr_hi",     1'b0, 1'b1, 18'h00010, 16'h1200, 2'b10, 0, 16'h0000, 2, 0, 2'b01, 4};
      vecs[3]  = '{"rd_12c3",   1'b1, 1'b0, 18'h00010, 16'h0000, 2'b00, 1, 16'h12C3, 0, 2, 2'b11, 4};
      vecs[4]  = '{"rd_top",    1'b1, 1'b0, 18'h3FFFF, 16'h0000, 2'b00, 1, 16'h5A5A, 0, 2, 2'b11, 4};
      vecs[5]  = '{"wr_top",    1'b0, 1'b1, 18'h3FFFF, 16'h7E81, 2'b11, 0, 16'h0000, 2, 0, 2'b00, 4};
      vecs[6]  = '{"both_beef", 1'b1, 1'b1, 18'h00020, 16'hBEEF, 2'b11, 0, 16'h0000, 2, 0, 2'b00, 4};
      vecs[7]  = '{"rd_beef",   1'b1, 1'b0, 18'h00020, 16'h0000, 2'b00, 1, 16'hBEEF, 0, 2, 2'b11, 4};
      vecs[8]  = '{"wr_be0",    1'b0, 1'b1, 18'h00040, 16'h3344, 2'b00, 0, 16'h0000, 2, 0, 2'b11, 4};
      vecs[9]  = '{"rd_be0",    1'b1, 1'b0, 18'h00040, 16'h0000, 2'b00, 1, 16'h9999, 0, 2, 2'b11, 4};
      vecs[10] = '{"rd_top2",   1'b1, 1'b0, 18'h3FFFF, 16'h0000, 2'b00, 1, 16'h7E81, 0, 2, 2'b11, 4};
      vecs[11] = '{"rd_post",   1'b1, 1'b0, 18'h00010, 16'h0000, 2'b00, 1, 16'h12C3, 0, 2, 2'b11, 4};
      vecs[12] = '{"rd_post2",  1'b1, 1'b0, 18'h00020, 16'h0000, 2'b00, 1, 16'hBEEF, 0, 2, 2'b11, 4};

      mem[18'h00040] = 16'h9999;
      mem[18'h3FFFF] = 16'h5A5A;

      // Reset held while the master toggles requests.
      reset = 1'b1; avs_read = 1'b0; avs_write = 1'b0; avs_address = '0;
      avs_writedata = '0; avs_byteenable = '0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         avs_read = (i % 2 == 0); avs_write = (i % 2 == 1);
         #1;
         chk("rst_waitreq", 32'(avs_waitrequest), 32'd1);
      end
      chk("rst_strobes", {28'd0, sram_ce_n, sram_oe_n, sram_we_n, 1'b0}, 32'hE);
      chk("rst_be_n", 32'(sram_be_n), 32'h3);
      chk("rst_dq_oe", 32'(dut.r_dq_oe), 32'd0);
      chk("rst_addr", 32'(sram_addr), 32'd0);
      chk("rst_rdata", {15'd0, avs_readdatavalid, avs_readdata}, 32'd0);
      @(negedge clk);
      avs_read = 1'b0; avs_write = 1'b0;
      reset = 1'b0;
      #1;
      chk("rel_waitreq", 32'(avs_waitrequest), 32'd0);

      for (int i = 0; i < 11; i++) do_op(vecs[i]);

      chk("turn_gap_ok", 32'(min_gap >= 1), 32'd1);
      chk("bus_overlap", 32'(overlap), 32'd0);

      // Reset in the first READ cycle: strobes rise at once, no valid pulse afterwards.
      @(negedge clk);
      avs_read = 1'b1; avs_address = 18'h00010;
      @(posedge clk);
      #1;
      avs_read = 1'b0;
      @(negedge clk);
      chk("mr_oe_low", 32'(sram_oe_n), 32'd0);
      reset = 1'b1;
      #1;
      chk("mr_strobes", {29'd0, sram_ce_n, sram_oe_n, avs_waitrequest}, 32'h7);
      @(negedge clk);
      reset = 1'b0;
      begin
         int rdv_seen;
         rdv_seen = 0;
         for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (avs_readdatavalid) rdv_seen++;
         end
         chk("mr_no_rdv", 32'(rdv_seen), 32'd0);
      end

      // Reset in the first WRITE cycle: WE/CE rise and DQ released at once.
      avs_write = 1'b1; avs_address = 18'h00030; avs_writedata = 16'h1111; avs_byteenable = 2'b11;
      @(posedge clk);
      #1;
      avs_write = 1'b0;
      @(negedge clk);
      chk("mw_we_low", 32'(sram_we_n), 32'd0);
      reset = 1'b1;
      #1;
      chk("mw_strobes", {29'd0, sram_ce_n, sram_we_n, dut.r_dq_oe}, 32'h6);
      @(negedge clk);
      reset = 1'b0;

      for (int i = 11; i < 13; i++) do_op(vecs[i]);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
